lut_config_loader: RTL

- Upstream configuration stage for one fracturable dual-LUT slice.
- Receives the slice bitstream one bit at a time over a valid/ready serial handshake and assembles a full configuration word.
- Presents the word on a parallel bus with a single-cycle, glitch-free cen strobe to program both LUTs and the fracture bit.
- Then holds the committed word until a restart is requested.

---
 rtl/lut_config_loader.sv | 97 +++++++++
 1 files changed

// File: rtl/lut_config_loader.sv
// Serial-to-parallel configuration loader for a fracturable dual-LUT slice.
// Assembles a CFG_WIDTH-bit word MSB-first, commits it with a one-cycle cen strobe, then holds it.
module lut_config_loader #(
  parameter int unsigned INPUTS    = 4,
  parameter int unsigned MEM_SIZE  = 2 ** INPUTS,
  parameter int unsigned CFG_WIDTH = 2 * MEM_SIZE + 1,
  parameter int unsigned CNT_W     = $clog2(CFG_WIDTH + 1)
) (
  input  logic                 cclk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_ready,
  input  logic                 cfg_restart,
  output logic [CFG_WIDTH-1:0] config_out,
  output logic                 cen,
  output logic                 loaded,
  output logic [CNT_W-1:0]     bit_count
);

  typedef enum logic [1:0] {StShift, StCommit, StDone} state_e;

  state_e               r_state, w_state_d;
  logic [CFG_WIDTH-1:0] r_shreg, w_shreg_d;
  logic [CFG_WIDTH-1:0] r_config, w_config_d;
  logic [CNT_W-1:0]     r_count, w_count_d;
  logic                 r_cen, w_cen_d;
  logic                 r_loaded, w_loaded_d;
  logic [CFG_WIDTH-1:0] w_shifted;

  assign w_shifted  = {r_shreg[CFG_WIDTH-2:0], cfg_bit};
  assign cfg_ready  = (r_state == StShift);
  assign config_out = r_config;
  assign cen        = r_cen;
  assign loaded     = r_loaded;
  assign bit_count  = r_count;

  always_comb begin
    w_state_d  = r_state;
    w_shreg_d  = r_shreg;
    w_config_d = r_config;
    w_count_d  = r_count;
    w_cen_d    = 1'b0;
    w_loaded_d = r_loaded;
    unique case (r_state)
      StShift: begin
        // Restart wins over a simultaneous transfer, even the final bit.
        if (cfg_restart) begin
          w_shreg_d = '0;
          w_count_d = '0;
        end else if (cfg_valid) begin
          w_shreg_d = w_shifted;
          if (r_count == CNT_W'(CFG_WIDTH - 1)) begin
            w_config_d = w_shifted;
            w_cen_d    = 1'b1;
            w_count_d  = CNT_W'(CFG_WIDTH);
            w_state_d  = StCommit;
          end else begin
            w_count_d = r_count + 1'b1;
          end
        end
      end
      StCommit: begin
        w_loaded_d = 1'b1;
        w_state_d  = StDone;
      end
      StDone: begin
        if (cfg_restart) begin
          w_state_d  = StShift;
          w_shreg_d  = '0;
          w_count_d  = '0;
          w_loaded_d = 1'b0;
        end
      end
      default: w_state_d = StShift;
    endcase
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StShift;
      r_shreg  <= '0;
      r_config <= '0;
      r_count  <= '0;
      r_cen    <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_shreg  <= w_shreg_d;
      r_config <= w_config_d;
      r_count  <= w_count_d;
      r_cen    <= w_cen_d;
      r_loaded <= w_loaded_d;
    end
  end

endmodule
